parallel_unary_gen7: RTL and testbench

Binary-to-unary stream generator, the transmit-side counterpart of the 7-input parallel counter. It accepts a WIDTH-bit binary magnitude and emits it as a burst of 7-lane thermometer-coded beats. The per-beat popcounts sum exactly to the magnitude, so feeding the lanes into a 7:3 parallel counter and accumulating reconstructs the value. It sits at the front of the unary datapath, converting binary operands into parallel unary bitstreams for the scaled adders.

---
 rtl/parallel_unary_gen7.sv | 61 ++++++
 tb/tb_parallel_unary_gen7.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/parallel_unary_gen7.sv
// parallel_unary_gen7: binary magnitude to 7-lane thermometer beat stream (define PUGEN_BACKTOBACK_EN for bubble-free back-to-back bursts)
module parallel_unary_gen7 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_bits,
    output logic             out_last,
    output logic             busy
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             emit, big, in_hs, out_hs;
    logic [2:0]       n;
    logic [6:0]       therm;
    assign emit      = state_q == EMIT;
    assign big       = rem_q > WIDTH'(7);
    assign n         = big ? 3'd7 : rem_q[2:0];
    assign therm     = ~(7'h7F << n);
    assign busy      = emit;
    assign out_valid = emit;
    assign out_bits  = emit ? therm : 7'h00;
    assign out_last  = emit && !big;
`ifdef PUGEN_BACKTOBACK_EN
    // the final beat's handshake edge can also accept the next value
    assign in_ready  = !emit || (out_last && out_ready);
`else
    assign in_ready  = !emit;
`endif
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    // next state: consume a beat, then let a newly accepted value override
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (out_hs) begin
            rem_d   = rem_q - WIDTH'(n);
            state_d = out_last ? IDLE : EMIT;
        end
        if (in_hs) begin
            rem_d   = in_value;
            state_d = EMIT;
        end
    end
    // state registers; reset overrides any handshake on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: tb/tb_parallel_unary_gen7.sv
// tb_parallel_unary_gen7: directed and table-driven checks of the unary beat generator
module tb_parallel_unary_gen7;
    localparam int W = 8;
    typedef struct {
        int         v;
        int         beats;
        logic [6:0] last_bits;
    } vec_t;
    logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [W-1:0] in_value = '0;
    logic         in_ready, out_valid, out_last, busy;
    logic [6:0]   out_bits;
    int           checks = 0, errors = 0;
    vec_t         tbl [11];
    typedef struct {
        logic       valid;
        logic [6:0] bits;
        logic       last;
    } row_t;
    row_t         seq [4];

    always #5 clk = ~clk;

    parallel_unary_gen7 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_last(out_last), .busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic burst(input int v, input int exp_beats, input logic [6:0] exp_last_bits, input bit stall);
        int beats, sum, cyc;
        logic [6:0] prev_bits;
        logic prev_last;
        bit prev_stalled, done;
        @(negedge clk);
        chk("accept_ready", in_ready, 1);
        in_valid = 1; in_value = W'(v); out_ready = 1;
        @(negedge clk);
        in_valid = 0; in_value = W'($urandom);
        chk("latency_valid", out_valid, 1);
        chk("busy_in_burst", busy, 1);
        beats = 0; sum = 0; cyc = 0; prev_stalled = 0; done = 0;
        prev_bits = '0; prev_last = 0;
        while (!done && cyc < 400) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (prev_stalled) begin
                chk("stall_bits", out_bits, prev_bits);
                chk("stall_last", out_last, prev_last);
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                sum += $countones(out_bits);
                chk("beat_bits", out_bits, (beats == exp_beats - 1) ? exp_last_bits : 7'h7F);
                chk("beat_last", out_last, beats == exp_beats - 1);
                beats++;
                done = out_last || beats > exp_beats;
            end
            prev_stalled = out_valid && !out_ready;
            prev_bits = out_bits;
            prev_last = out_last;
        end
        if (!done) chk("burst_timeout", 0, 1);
        chk("beat_count", beats, exp_beats);
        chk("burst_sum", sum, v);
        @(negedge clk);
        out_ready = 1;
        chk("post_valid", out_valid, 0);
        chk("post_ready", in_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        tbl[0]  = '{0,   1,  7'h00};
        tbl[1]  = '{1,   1,  7'h01};
        tbl[2]  = '{6,   1,  7'h3F};
        tbl[3]  = '{7,   1,  7'h7F};
        tbl[4]  = '{8,   2,  7'h01};
        tbl[5]  = '{14,  2,  7'h7F};
        tbl[6]  = '{17,  3,  7'h07};
        tbl[7]  = '{49,  7,  7'h7F};
        tbl[8]  = '{50,  8,  7'h01};
        tbl[9]  = '{100, 15, 7'h03};
        tbl[10] = '{255, 37, 7'h07};
`ifdef PUGEN_BACKTOBACK_EN
        seq[0] = '{1'b1, 7'h7F, 1'b0};
        seq[1] = '{1'b1, 7'h7F, 1'b1};
        seq[2] = '{1'b1, 7'h07, 1'b1};
        seq[3] = '{1'b0, 7'h00, 1'b0};
`else
        seq[0] = '{1'b1, 7'h7F, 1'b0};
        seq[1] = '{1'b1, 7'h7F, 1'b1};
        seq[2] = '{1'b0, 7'h00, 1'b0};
        seq[3] = '{1'b1, 7'h07, 1'b1};
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bits", out_bits, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        for (int i = 0; i < 11; i++) burst(tbl[i].v, tbl[i].beats, tbl[i].last_bits, 0);
        burst(255, 37, 7'h07, 1);
        // reset during beat 2 of 30
        @(negedge clk);
        in_valid = 1; in_value = 8'd30; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("b2_bits", out_bits, 7'h7F);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        burst(7, 1, 7'h7F, 0);
        // reset together with an input handshake
        @(negedge clk);
        rst = 1; in_valid = 1; in_value = 8'd5;
        @(negedge clk);
        rst = 0; in_valid = 0;
        chk("rst_hs_valid", out_valid, 0);
        chk("rst_hs_busy", busy, 0);
        // 14 then 3 with in_valid held
        begin
            bit sent3;
            sent3 = 0;
            @(negedge clk);
            in_valid = 1; in_value = 8'd14; out_ready = 1;
            @(posedge clk);
            #1 in_value = 8'd3;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("seq_valid", out_valid, seq[k].valid);
                chk("seq_bits", out_bits, seq[k].bits);
                chk("seq_last", out_last, seq[k].last);
                if (!sent3 && in_ready) begin
                    sent3 = 1;
                    @(posedge clk);
                    #1 in_valid = 0;
                end
            end
            chk("seq_sent3", sent3, 1);
            repeat (3) @(negedge clk);
            chk("seq_idle", busy, 0);
        end
        // randomised sweep with stalls
        for (int i = 0; i < 30; i++) begin
            int v, b, r;
            v = $urandom_range(0, 255);
            b = (v == 0) ? 1 : (v + 6) / 7;
            r = v - 7 * (b - 1);
            burst(v, b, 7'((1 << r) - 1), 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
